fir_sample_loader: RTL and testbench

- Upstream feeder stage for the non-pipelined 5-tap FIR engine.
- Accepts an input sample stream over a valid/ready handshake and packs it into an internal sample RAM (one frame of FRAME_LEN entries).
- Zero-pads short frames, then hands the frame to the FIR with a start/done handshake and exposes a synchronous read port.
- Holds off the input stream while the FIR owns the buffer.

---
 rtl/fir_sample_loader.sv | 121 ++++++++++++
 tb/tb_fir_sample_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_loader.sv
// Feeder for the 5-tap FIR engine: packs a valid/ready sample stream into a frame RAM,
// zero-pads short frames, then hands the buffer to the FIR with a start/done handshake.
module fir_sample_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  fir_start,
    input  logic                  fir_done,
    output logic [ADDR_WIDTH:0]   fir_len,
    input  logic [ADDR_WIDTH-1:0] fir_rd_addr,
    output logic [DATA_WIDTH-1:0] fir_rd_data,
    output logic [15:0]           frame_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_LEN  = (ADDR_WIDTH + 1)'(FRAME_LEN);

    typedef enum logic [1:0] {
        FILL,
        PAD,
        START,
        BUSY
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0]   wr_ptr_next;
    logic [ADDR_WIDTH:0]     fir_len_next;
    logic                    ram_we;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [DATA_WIDTH-1:0]   ram [2**ADDR_WIDTH];

    // Sample writes and pad writes share the single RAM write port at wr_ptr.
    always_comb begin
        state_next   = state;
        wr_ptr_next  = wr_ptr;
        fir_len_next = fir_len;
        ram_we       = 1'b0;
        ram_wdata    = '0;
        case (state)
            FILL: begin
                if (s_valid && s_ready) begin
                    ram_we    = 1'b1;
                    ram_wdata = s_data;
                    if (wr_ptr == LAST_ADDR) begin
                        fir_len_next = FULL_LEN;
                        wr_ptr_next  = '0;
                        state_next   = START;
                    end else begin
                        wr_ptr_next = wr_ptr + ADDR_WIDTH'(1);
                        if (s_last) begin
                            fir_len_next = {1'b0, wr_ptr} + (ADDR_WIDTH + 1)'(1);
                            state_next   = PAD;
                        end
                    end
                end
            end
            PAD: begin
                ram_we = 1'b1;
                if (wr_ptr == LAST_ADDR) begin
                    wr_ptr_next = '0;
                    state_next  = START;
                end else begin
                    wr_ptr_next = wr_ptr + ADDR_WIDTH'(1);
                end
            end
            START: state_next = BUSY;
            BUSY: begin
                if (fir_done) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // s_ready and fir_start are registered decodes of the next state, so they track state only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            wr_ptr      <= '0;
            fir_len     <= '0;
            s_ready     <= 1'b1;
            fir_start   <= 1'b0;
            frame_count <= '0;
        end else begin
            state     <= state_next;
            wr_ptr    <= wr_ptr_next;
            fir_len   <= fir_len_next;
            s_ready   <= (state_next == FILL);
            fir_start <= (state_next == START);
            if (state_next == START) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            ram[wr_ptr] <= ram_wdata;
        end
    end

    // Read-first: a same-address write in this cycle is not visible until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            fir_rd_data <= '0;
        end else begin
            fir_rd_data <= ram[fir_rd_addr];
        end
    end

endmodule

// File: tb/tb_fir_sample_loader.sv
// Directed and table-driven checks for fir_sample_loader: full and short frames, BUSY
// back-pressure, ignored fir_done pulses, reset recovery and randomly gapped frames.
module tb_fir_sample_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        fir_start;
    logic        fir_done;
    logic [4:0]  fir_len;
    logic [3:0]  fir_rd_addr;
    logic [7:0]  fir_rd_data;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       s_valid;
        logic [7:0] s_data;
        logic       s_last;
        logic       fir_done;
        logic       exp_ready;
        logic       exp_start;
    } vec_t;

    vec_t       vecs [17];
    logic [7:0] sb [16];

    fir_sample_loader #(.DATA_WIDTH(8), .FRAME_LEN(16), .ADDR_WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .fir_start   (fir_start),
        .fir_done    (fir_done),
        .fir_len     (fir_len),
        .fir_rd_addr (fir_rd_addr),
        .fir_rd_data (fir_rd_data),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic done);
        s_valid  = v;
        s_data   = d;
        s_last   = l;
        fir_done = done;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic readCheck(input logic [3:0] addr, input logic [7:0] exp_data, input string name);
        fir_rd_addr = addr;
        tick();
        checkOutput(name, 32'(fir_rd_data), 32'(exp_data));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_ready"}, 32'(s_ready), 32'd1);
        checkOutput({tag, "_start"}, 32'(fir_start), 32'd0);
        checkOutput({tag, "_len"}, 32'(fir_len), 32'd0);
        checkOutput({tag, "_count"}, 32'(frame_count), 32'd0);
        checkOutput({tag, "_rdata"}, 32'(fir_rd_data), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] d;
        int         wr;

        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b1, 8'(i + 1), 1'b0, 1'b0, 1'(i < 15), 1'(i == 15)};
        end
        vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; fir_done = 1'b0; fir_rd_addr = '0;
        tick();
        tick();
        checkReset("por");
        rst = 1'b0;

        $display("[TB] full frame 1..16");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].s_valid, vecs[i].s_data, vecs[i].s_last, vecs[i].fir_done);
            checkOutput($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d_start", i), 32'(fir_start), 32'(vecs[i].exp_start));
        end
        checkOutput("f1_len", 32'(fir_len), 32'd16);
        checkOutput("f1_count", 32'(frame_count), 32'd1);
        for (int a = 0; a < 16; a++) readCheck(4'(a), 8'(a + 1), $sformatf("f1_rd%0d", a));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("f1_done_ready", 32'(s_ready), 32'd1);

        $display("[TB] short frame with padding");
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA3, 1'b1, 1'b0);
        checkOutput("pad0_ready", 32'(s_ready), 32'd0);
        checkOutput("pad0_start", 32'(fir_start), 32'd0);
        for (int k = 1; k < 13; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            checkOutput($sformatf("pad%0d_ready", k), 32'(s_ready), 32'd0);
            checkOutput($sformatf("pad%0d_start", k), 32'(fir_start), 32'd0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("short_start", 32'(fir_start), 32'd1);
        checkOutput("short_len", 32'(fir_len), 32'd3);
        tick();
        checkOutput("short_start_off", 32'(fir_start), 32'd0);
        checkOutput("short_count", 32'(frame_count), 32'd2);
        for (int a = 0; a < 16; a++) begin
            readCheck(4'(a), (a < 3) ? 8'(8'hA1 + a) : 8'h00, $sformatf("short_rd%0d", a));
        end

        $display("[TB] back-pressure while BUSY");
        s_valid = 1'b1; s_data = 8'h55;
        for (int k = 0; k < 20; k++) begin
            tick();
            checkOutput($sformatf("busy%0d_ready", k), 32'(s_ready), 32'd0);
        end
        for (int a = 0; a < 16; a++) begin
            readCheck(4'(a), (a < 3) ? 8'(8'hA1 + a) : 8'h00, $sformatf("hold_rd%0d", a));
        end
        fir_done = 1'b1;
        tick();
        fir_done = 1'b0;
        checkOutput("release_ready", 32'(s_ready), 32'd1);
        tick();

        $display("[TB] fir_done ignored in FILL and START");
        for (int j = 1; j < 5; j++) applyStimulus(1'b1, 8'(8'h60 + j), 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("fill_done_ready", 32'(s_ready), 32'd1);
        for (int j = 5; j < 16; j++) applyStimulus(1'b1, 8'(8'h60 + j), 1'b0, 1'b0);
        checkOutput("f3_start", 32'(fir_start), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("start_done_ready", 32'(s_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            checkOutput($sformatf("f3_busy%0d_ready", k), 32'(s_ready), 32'd0);
        end
        checkOutput("f3_count", 32'(frame_count), 32'd3);
        checkOutput("f3_len", 32'(fir_len), 32'd16);
        readCheck(4'd0, 8'h55, "f3_rd0");
        for (int a = 1; a < 16; a++) readCheck(4'(a), 8'(8'h60 + a), $sformatf("f3_rd%0d", a));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("f3_done_ready", 32'(s_ready), 32'd1);

        $display("[TB] reset mid-frame and while BUSY");
        for (int j = 0; j < 7; j++) applyStimulus(1'b1, 8'(8'h70 + j), 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkReset("rst_mid");
        rst = 1'b0;
        for (int j = 0; j < 16; j++) begin
            applyStimulus(1'b1, 8'(8'h80 + j), 1'b0, 1'b0);
            checkOutput($sformatf("f4_start%0d", j), 32'(fir_start), 32'(j == 15));
        end
        tick();
        checkOutput("f4_count", 32'(frame_count), 32'd1);
        for (int a = 0; a < 16; a++) readCheck(4'(a), 8'(8'h80 + a), $sformatf("f4_rd%0d", a));
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkReset("rst_busy");
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("post_rst_ready", 32'(s_ready), 32'd1);
        checkOutput("post_rst_start", 32'(fir_start), 32'd0);
        fir_done = 1'b0;

        $display("[TB] three gapped frames");
        for (int f = 0; f < 3; f++) begin
            wr = 0;
            while (wr < 16) begin
                if ($urandom_range(0, 2) == 0) begin
                    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
                    checkOutput($sformatf("r%0d_gap_ready", f), 32'(s_ready), 32'd1);
                end else begin
                    d = 8'($urandom);
                    sb[wr] = d;
                    applyStimulus(1'b1, d, 1'b0, 1'b0);
                    wr++;
                    checkOutput($sformatf("r%0d_start%0d", f, wr), 32'(fir_start), 32'(wr == 16));
                end
            end
            tick();
            for (int a = 0; a < 16; a++) readCheck(4'(a), sb[a], $sformatf("r%0d_rd%0d", f, a));
            for (int k = 0; k < 64; k++) tick();
            checkOutput($sformatf("r%0d_busy_ready", f), 32'(s_ready), 32'd0);
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
            fir_done = 1'b0;
            checkOutput($sformatf("r%0d_done_ready", f), 32'(s_ready), 32'd1);
        end
        checkOutput("rand_count", 32'(frame_count), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
